// File: rtl/fighter_anim_ctrl.sv
// fighter_anim_ctrl
//   Per-fighter animation sequencer. Converts player requests and hit events
//   into the (anim_state, anim_frame) pair used by the sprite mapper. It also:
//     - paces frames on the video frame_tick
//     - locks out requests while jump, attack or hit is playing
//     - gives a hit priority over everything else
//     - flags the attack hitbox window for the collision logic
//
// Ports
//   clk         in   system clock
//   rst_n       in   async active-low reset
//   frame_tick  in   1-cycle pulse per video frame
//   move_req    in   walk held (level)
//   jump_req    in   jump request (level)
//   atk1_req    in   attack 1 request (level)
//   atk2_req    in   attack 2 request (level)
//   hit_in      in   1-cycle pulse, fighter was struck (any cycle)
//   anim_state  out  0 idle, 1 walk, 2 jump, 3 atk1, 4 atk2, 5 hit
//   anim_frame  out  frame index within the current state
//   busy        out  state is jump/atk1/atk2/hit (non-cancellable)
//   atk_active  out  attack state with ACT_LO <= anim_frame <= ACT_HI
//   anim_done   out  1-cycle pulse when jump/atk/hit completes
module fighter_anim_ctrl #(
    parameter int unsigned TICKS_PER_FRAME = 4,
    parameter int unsigned WALK_FRAMES     = 4,
    parameter int unsigned JUMP_FRAMES     = 16,
    parameter int unsigned ATK1_FRAMES     = 6,
    parameter int unsigned ATK2_FRAMES     = 8,
    parameter int unsigned HIT_FRAMES      = 12,
    parameter int unsigned ACT_LO          = 2,
    parameter int unsigned ACT_HI          = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_req,
    input  logic       jump_req,
    input  logic       atk1_req,
    input  logic       atk2_req,
    input  logic       hit_in,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       busy,
    output logic       atk_active,
    output logic       anim_done
);

    localparam int unsigned TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WALK = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5
    } state_t;

    state_t          state, state_nx, req_state;
    logic [5:0]      frame, frame_nx, last_frame;
    logic [TW-1:0]   tick_cnt, tick_nx;
    logic            hit_pend, pend_nx;
    logic            done_nx, busy_nx, act_nx;
    logic            wrap;

    // Last frame index of the current busy state.
    always_comb begin
        last_frame = '0;
        case (state)
            S_JUMP:  last_frame = 6'(JUMP_FRAMES - 1);
            S_ATK1:  last_frame = 6'(ATK1_FRAMES - 1);
            S_ATK2:  last_frame = 6'(ATK2_FRAMES - 1);
            S_HIT:   last_frame = 6'(HIT_FRAMES - 1);
            default: last_frame = '0;
        endcase
    end

    // Request arbitration used only from IDLE/WALK.
    always_comb begin
        if (atk1_req)      req_state = S_ATK1;
        else if (atk2_req) req_state = S_ATK2;
        else if (jump_req) req_state = S_JUMP;
        else if (move_req) req_state = S_WALK;
        else               req_state = S_IDLE;
    end

    assign wrap = (tick_cnt == TW'(TICKS_PER_FRAME - 1));

    always_comb begin
        state_nx = state;
        frame_nx = frame;
        tick_nx  = tick_cnt;
        pend_nx  = hit_pend | hit_in;
        done_nx  = 1'b0;

        if (frame_tick) begin
            // Any pending or coincident hit is consumed on this tick.
            pend_nx = 1'b0;
            if (hit_pend || hit_in) begin
                state_nx = S_HIT;
                frame_nx = '0;
                tick_nx  = '0;
            end else if (state == S_IDLE || state == S_WALK) begin
                if (req_state != state) begin
                    state_nx = req_state;
                    frame_nx = '0;
                    tick_nx  = '0;
                end else if (state == S_WALK) begin
                    if (wrap) begin
                        tick_nx  = '0;
                        frame_nx = (frame == 6'(WALK_FRAMES - 1)) ? '0 : frame + 6'd1;
                    end else begin
                        tick_nx = tick_cnt + TW'(1);
                    end
                end
            end else begin
                if (wrap) begin
                    tick_nx = '0;
                    if (frame == last_frame) begin
                        // Exit: requests other than move are not looked at here.
                        state_nx = move_req ? S_WALK : S_IDLE;
                        frame_nx = '0;
                        done_nx  = 1'b1;
                    end else begin
                        frame_nx = frame + 6'd1;
                    end
                end else begin
                    tick_nx = tick_cnt + TW'(1);
                end
            end
        end

        busy_nx = (state_nx == S_JUMP) || (state_nx == S_ATK1) ||
                  (state_nx == S_ATK2) || (state_nx == S_HIT);
        act_nx  = ((state_nx == S_ATK1) || (state_nx == S_ATK2)) &&
                  (frame_nx >= 6'(ACT_LO)) && (frame_nx <= 6'(ACT_HI));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            frame      <= '0;
            tick_cnt   <= '0;
            hit_pend   <= 1'b0;
            anim_done  <= 1'b0;
            busy       <= 1'b0;
            atk_active <= 1'b0;
        end else begin
            state      <= state_nx;
            frame      <= frame_nx;
            tick_cnt   <= tick_nx;
            hit_pend   <= pend_nx;
            anim_done  <= done_nx;
            busy       <= busy_nx;
            atk_active <= act_nx;
        end
    end

    assign anim_state = state;
    assign anim_frame = frame;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// tb_fighter_anim_ctrl
//   Scoreboard bench for fighter_anim_ctrl. The driver applies inputs on the
//   falling edge, advances a tick-age reference model and queues the expected
//   outputs; the monitor compares them just after each rising edge.
module tb_fighter_anim_ctrl;

    localparam int T  = 4;
    localparam int WF = 4;
    localparam int JF = 16;
    localparam int A1 = 6;
    localparam int A2 = 8;
    localparam int HF = 12;
    localparam int LO = 2;
    localparam int HI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, move_req = 1'b0, jump_req = 1'b0;
    logic       atk1_req = 1'b0, atk2_req = 1'b0, hit_in = 1'b0;
    logic [3:0] anim_state;
    logic [5:0] anim_frame;
    logic       busy, atk_active, anim_done;

    fighter_anim_ctrl #(
        .TICKS_PER_FRAME(T), .WALK_FRAMES(WF), .JUMP_FRAMES(JF),
        .ATK1_FRAMES(A1), .ATK2_FRAMES(A2), .HIT_FRAMES(HF),
        .ACT_LO(LO), .ACT_HI(HI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_req(move_req), .jump_req(jump_req), .atk1_req(atk1_req),
        .atk2_req(atk2_req), .hit_in(hit_in), .anim_state(anim_state),
        .anim_frame(anim_frame), .busy(busy), .atk_active(atk_active),
        .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    // {state[3:0], frame[5:0], busy, atk_active, anim_done}
    logic [12:0] expq[$];
    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Reference model: state plus number of frame_ticks spent in it.
    int m_state = 0;
    int m_age   = 0;
    bit m_pend  = 0;

    function automatic int flen(int s);
        case (s)
            2: return JF;
            3: return A1;
            4: return A2;
            5: return HF;
            default: return 1;
        endcase
    endfunction

    task automatic drive(bit r, bit tk, bit mv, bit jp, bit a1, bit a2, bit ht);
        int ns, fr;
        bit done, bsy, act;
        @(negedge clk);
        rst_n = r; frame_tick = tk; move_req = mv; jump_req = jp;
        atk1_req = a1; atk2_req = a2; hit_in = ht;
        done = 0;
        if (!r) begin
            m_state = 0; m_age = 0; m_pend = 0;
        end else if (tk) begin
            if (m_pend || ht) begin
                m_state = 5; m_age = 0;
            end else if (m_state <= 1) begin
                ns = a1 ? 3 : a2 ? 4 : jp ? 2 : mv ? 1 : 0;
                if (ns != m_state) begin
                    m_state = ns; m_age = 0;
                end else if (m_state == 1) begin
                    m_age++;
                end
            end else if (m_age + 1 == flen(m_state) * T) begin
                done = 1; m_state = mv ? 1 : 0; m_age = 0;
            end else begin
                m_age++;
            end
            m_pend = 0;
        end else if (ht) begin
            m_pend = 1;
        end
        fr  = (m_state == 0) ? 0 : (m_state == 1) ? (m_age / T) % WF : m_age / T;
        bsy = (m_state >= 2);
        act = (m_state == 3 || m_state == 4) && fr >= LO && fr <= HI;
        expq.push_back({4'(m_state), 6'(fr), bsy, act, done});
    endtask

    // n frame_ticks with one idle cycle between each, requests held.
    task automatic ticks(int n, bit mv, bit jp, bit a1, bit a2);
        for (int i = 0; i < n; i++) begin
            drive(1, 1, mv, jp, a1, a2, 0);
            drive(1, 0, mv, jp, a1, a2, 0);
        end
    endtask

    // Monitor
    initial begin
        logic [12:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                g = {anim_state, anim_frame, busy, atk_active, anim_done};
                tests++;
                if (g !== e) begin
                    failed++;
                    $display("FAIL outputs cycle %0d: got st=%0d fr=%0d busy=%0b act=%0b done=%0b, expected st=%0d fr=%0d busy=%0b act=%0b done=%0b",
                             cyc, g[12:9], g[8:3], g[2], g[1], g[0],
                             e[12:9], e[8:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Driver
    initial begin
        int wait_cnt;
        bit mv, jp, a1, a2;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Single-tick atk1 from idle, full 24-tick run and exit to idle.
        ticks(1, 0, 0, 1, 0);
        ticks(30, 0, 0, 0, 0);

        // Atk1 held alongside atk2/jump: only atk1 is ever taken.
        ticks(60, 0, 1, 1, 1);
        ticks(30, 0, 0, 0, 0);

        // Hit between ticks mid-atk2, then a restarting hit at hit frame 7.
        ticks(1, 0, 0, 0, 1);
        ticks(10, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks(29, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        ticks(55, 0, 0, 0, 0);

        // Walk held 20 ticks, then release.
        ticks(20, 1, 0, 0, 0);
        ticks(3, 0, 0, 0, 0);

        // Hit coincident with the atk1 exit tick.
        ticks(1, 0, 0, 1, 0);
        ticks(23, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 1);
        ticks(50, 0, 0, 0, 0);

        // Jump with move held at exit goes to walk.
        ticks(1, 0, 1, 0, 0);
        ticks(70, 1, 0, 0, 0);

        // Async reset in the middle of atk1.
        ticks(1, 0, 0, 1, 0);
        ticks(9, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with stretches of held requests.
        mv = 0; jp = 0; a1 = 0; a2 = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                mv = ($urandom_range(0, 1) == 1);
                jp = ($urandom_range(0, 5) == 0);
                a1 = ($urandom_range(0, 5) == 0);
                a2 = ($urandom_range(0, 5) == 0);
            end
            drive(($urandom_range(0, 999) != 0), ($urandom_range(0, 2) == 0),
                  mv, jp, a1, a2, ($urandom_range(0, 39) == 0));
        end
        drive(1, 0, 0, 0, 0, 0, 0);

        wait_cnt = 0;
        while (expq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (expq.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expected entries left, required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
